// File: rtl/clk_period_monitor.sv
// Multi-channel strobe period checker: measures tick-to-tick intervals against exp_period +/- tol.
// Optional stopped-strobe timeout is enabled by defining CLK_PERIOD_MONITOR_TIMEOUT_EN.
module clk_period_monitor #(
    parameter int NCH      = 4,
    parameter int CW       = 16,
    parameter int ECW      = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NCH-1:0]     tick,
    input  logic [CW-1:0]      exp_period,
    input  logic [CW-1:0]      tol,
    input  logic               clr_err,
    output logic [NCH-1:0]     pass,
    output logic [NCH-1:0]     fail,
    output logic [NCH*CW-1:0]  meas_period,
    output logic [NCH*ECW-1:0] err_cnt,
    output logic [NCH-1:0]     locked,
    output logic               alarm
);

    localparam int SW = $clog2(LOCK_CNT + 1);

    typedef enum logic {IDLE, MEAS} state_t;

    // Window bounds in CW+1 bits so exp_period + tol never wraps.
    logic [CW:0] win_hi;
    logic [CW:0] exp_ext;
    logic [CW:0] tol_ext;
    logic [NCH-1:0] fail_next;
    logic alarm_reg;

    assign exp_ext = {1'b0, exp_period};
    assign tol_ext = {1'b0, tol};
    assign win_hi  = exp_ext + tol_ext;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t          state_reg, state_next;
        logic [CW-1:0]   cnt_reg, cnt_next;
        logic [CW-1:0]   meas_reg, meas_next;
        logic [ECW-1:0]  err_reg, err_next;
        logic [SW-1:0]   streak_reg, streak_next;
        logic            pass_reg, pass_next;
        logic            fail_reg, ch_fail_next;
        logic [CW:0]     cnt_ext;
        logic            in_window;
        logic            timeout_hit;

        assign cnt_ext   = {1'b0, cnt_reg};
        assign in_window = (cnt_ext + tol_ext >= exp_ext) && (cnt_ext <= win_hi);
`ifdef CLK_PERIOD_MONITOR_TIMEOUT_EN
        assign timeout_hit = (cnt_ext == win_hi);
`else
        assign timeout_hit = 1'b0;
`endif

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            meas_next    = meas_reg;
            streak_next  = streak_reg;
            pass_next    = 1'b0;
            ch_fail_next = 1'b0;
            if (!en) begin
                state_next  = IDLE;
                cnt_next    = '0;
                streak_next = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        cnt_next = '0;
                        if (tick[gi]) begin
                            state_next = MEAS;
                            cnt_next   = CW'(1);
                        end
                    end
                    MEAS: begin
                        if (tick[gi]) begin
                            meas_next = cnt_reg;
                            cnt_next  = CW'(1);
                            if (in_window) begin
                                pass_next = 1'b1;
                                if (streak_reg != SW'(LOCK_CNT))
                                    streak_next = streak_reg + SW'(1);
                            end else begin
                                ch_fail_next = 1'b1;
                                streak_next  = '0;
                            end
                        end else if (timeout_hit) begin
                            // Strobe stopped: flag it and wait for a fresh arming tick.
                            ch_fail_next = 1'b1;
                            streak_next  = '0;
                            state_next   = IDLE;
                            cnt_next     = '0;
                        end else if (cnt_reg != '1) begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            err_next = err_reg;
            if (clr_err)
                err_next = '0;
            else if (ch_fail_next && err_reg != '1)
                err_next = err_reg + ECW'(1);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg  <= IDLE;
                cnt_reg    <= '0;
                meas_reg   <= '0;
                err_reg    <= '0;
                streak_reg <= '0;
                pass_reg   <= 1'b0;
                fail_reg   <= 1'b0;
            end else begin
                state_reg  <= state_next;
                cnt_reg    <= cnt_next;
                meas_reg   <= meas_next;
                err_reg    <= err_next;
                streak_reg <= streak_next;
                pass_reg   <= pass_next;
                fail_reg   <= ch_fail_next;
            end
        end

        assign fail_next[gi]                = ch_fail_next;
        assign pass[gi]                     = pass_reg;
        assign fail[gi]                     = fail_reg;
        assign meas_period[gi*CW +: CW]     = meas_reg;
        assign err_cnt[gi*ECW +: ECW]       = err_reg;
        assign locked[gi]                   = (streak_reg == SW'(LOCK_CNT));
    end

    // clr_err outranks a coincident fail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            alarm_reg <= 1'b0;
        else if (clr_err)
            alarm_reg <= 1'b0;
        else if (|fail_next)
            alarm_reg <= 1'b1;
    end

    assign alarm = alarm_reg;

endmodule
